// File: rtl/microwave_pwr.sv
// Microwave oven controller: keypad time/power entry, BCD countdown,
// duty-cycled magnetron enable over a fixed window, and a completion beep.
//
// Input handshake: every control input (keypad digit, key_pwr, start, stop)
// is a single-cycle pulse sampled on the rising clock edge; there is no
// back-pressure, so a pulse not acted upon in its cycle is simply dropped.
// door_closed is a level. When several inputs arrive in one cycle the
// precedence is stop > door open > start > key_pwr > digit.
module microwave_pwr #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int PWR_WINDOW  = 10,
  parameter int DONE_BEEP_S = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] keypad,
  input  logic       key_pwr,
  input  logic       start,
  input  logic       stop,
  input  logic       door_closed,
  output logic       mag,
  output logic [2:0] state,
  output logic [3:0] mins,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] power,
  output logic       beep
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_PWR_SEL = 3'd1;
  localparam logic [2:0] ST_COOK    = 3'd2;
  localparam logic [2:0] ST_PAUSE   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam int TW = $clog2(TICK_DIV);
  localparam int WW = (PWR_WINDOW > 1) ? $clog2(PWR_WINDOW) : 1;
  localparam int BW = (DONE_BEEP_S > 1) ? $clog2(DONE_BEEP_S) : 1;

  // Internal counters: cycles within the current second, position in the
  // magnetron duty window, and seconds spent beeping in DONE.
  logic [TW-1:0] tick_cnt;
  logic [WW-1:0] win_cnt;
  logic [BW-1:0] beep_cnt;

  // Next-state values
  logic [2:0]    state_n;
  logic [3:0]    mins_n;
  logic [3:0]    tens_n;
  logic [3:0]    ones_n;
  logic [3:0]    power_n;
  logic [TW-1:0] tick_n;
  logic [WW-1:0] win_n;
  logic [BW-1:0] beep_cnt_n;
  logic          mag_n;
  logic          beep_n;

  // Keypad decode and helpers
  logic       digit_valid;
  logic [3:0] digit;
  logic       tick_hit;
  logic       win_last;
  logic       time_zero;

  // BCD decrement of the displayed time
  logic [3:0] dec_mins;
  logic [3:0] dec_tens;
  logic [3:0] dec_ones;
  logic       borrow_ones;
  logic       borrow_tens;
  logic       dec_zero;

  // Duty-cycle comparison operands, widened so no product overflows
  logic [31:0] duty_lhs;
  logic [31:0] duty_rhs;

  // Decode a single pressed digit; zero or multiple bits count as no press.
  always_comb begin
    digit       = 4'd0;
    digit_valid = $onehot(keypad);
    for (int i = 0; i < 10; i++) begin
      if (keypad[i]) digit = 4'(i);
    end
  end

  // Counter terminal conditions and the all-zero time detector.
  always_comb begin
    tick_hit  = (tick_cnt == TW'(TICK_DIV - 1));
    win_last  = (win_cnt == WW'(PWR_WINDOW - 1));
    time_zero = (mins == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd0);
  end

  // One-second BCD countdown; seconds tens borrow from 5 so entered values
  // above 59 (e.g. 0:95) still count down digit by digit.
  always_comb begin
    borrow_ones = (sec_ones == 4'd0);
    borrow_tens = borrow_ones && (sec_tens == 4'd0);
    dec_ones    = borrow_ones ? 4'd9 : (sec_ones - 4'd1);
    if (borrow_ones) dec_tens = (sec_tens == 4'd0) ? 4'd5 : (sec_tens - 4'd1);
    else             dec_tens = sec_tens;
    dec_mins    = borrow_tens ? (mins - 4'd1) : mins;
    dec_zero    = (dec_mins == 4'd0) && (dec_tens == 4'd0) && (dec_ones == 4'd0);
  end

  // Main controller: next state, time, power and counter values.
  always_comb begin
    state_n    = state;
    mins_n     = mins;
    tens_n     = sec_tens;
    ones_n     = sec_ones;
    power_n    = power;
    tick_n     = tick_cnt;
    win_n      = win_cnt;
    beep_cnt_n = beep_cnt;

    case (state)
      ST_IDLE: begin
        if (stop) begin
          mins_n  = 4'd0;
          tens_n  = 4'd0;
          ones_n  = 4'd0;
          power_n = 4'd10;
        end else if (start && door_closed) begin
          // Quick start: an empty timer cooks for 30 seconds.
          if (time_zero) begin
            mins_n = 4'd0;
            tens_n = 4'd3;
            ones_n = 4'd0;
          end
          state_n = ST_COOK;
          tick_n  = '0;
          win_n   = '0;
        end else if (key_pwr) begin
          state_n = ST_PWR_SEL;
        end else if (digit_valid) begin
          mins_n = sec_tens;
          tens_n = sec_ones;
          ones_n = digit;
        end
      end

      ST_PWR_SEL: begin
        if (stop) begin
          state_n = ST_IDLE;
        end else if (digit_valid) begin
          power_n = (digit == 4'd0) ? 4'd10 : digit;
          state_n = ST_IDLE;
        end
      end

      ST_COOK: begin
        if (stop || !door_closed) begin
          state_n = ST_PAUSE;
        end else if (tick_hit) begin
          tick_n = '0;
          mins_n = dec_mins;
          tens_n = dec_tens;
          ones_n = dec_ones;
          win_n  = win_last ? '0 : (win_cnt + WW'(1));
          if (dec_zero) begin
            state_n    = ST_DONE;
            beep_cnt_n = '0;
          end
        end else begin
          tick_n = tick_cnt + TW'(1);
        end
      end

      ST_PAUSE: begin
        if (stop) begin
          state_n = ST_IDLE;
          mins_n  = 4'd0;
          tens_n  = 4'd0;
          ones_n  = 4'd0;
          power_n = 4'd10;
        end else if (start && door_closed) begin
          // Resume keeps the held tick and window phase.
          state_n = ST_COOK;
        end
      end

      ST_DONE: begin
        if (stop || !door_closed || digit_valid) begin
          state_n = ST_IDLE;
        end else if (tick_hit) begin
          tick_n = '0;
          if (beep_cnt == BW'(DONE_BEEP_S - 1)) state_n = ST_IDLE;
          else                                  beep_cnt_n = beep_cnt + BW'(1);
        end else begin
          tick_n = tick_cnt + TW'(1);
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Output enables derived from the upcoming state so they register together
  // with it: mag follows the duty window, beep marks the DONE state.
  always_comb begin
    duty_lhs = 32'(win_n) * 32'd10;
    duty_rhs = 32'(power_n) * 32'(PWR_WINDOW);
    mag_n    = (state_n == ST_COOK) && (duty_lhs < duty_rhs);
    beep_n   = (state_n == ST_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      mins     <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
      power    <= 4'd10;
      mag      <= 1'b0;
      beep     <= 1'b0;
      tick_cnt <= '0;
      win_cnt  <= '0;
      beep_cnt <= '0;
    end else begin
      state    <= state_n;
      mins     <= mins_n;
      sec_tens <= tens_n;
      sec_ones <= ones_n;
      power    <= power_n;
      mag      <= mag_n;
      beep     <= beep_n;
      tick_cnt <= tick_n;
      win_cnt  <= win_n;
      beep_cnt <= beep_cnt_n;
    end
  end

endmodule

// File: tb/tb_microwave_pwr.sv
// Bench for microwave_pwr: directed scenarios with hand-computed literals,
// plus a cycle-level reference model compared on every falling edge.
module tb_microwave_pwr;

  localparam int TICK_DIV    = 4;
  localparam int PWR_WINDOW  = 10;
  localparam int DONE_BEEP_S = 3;

  localparam int S_IDLE = 0, S_PWR = 1, S_COOK = 2, S_PAUSE = 3, S_DONE = 4;

  // Clock and reset
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] keypad = '0;
  logic       key_pwr = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       door_closed = 1'b1;

  logic       mag;
  logic [2:0] state;
  logic [3:0] mins;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic [3:0] power;
  logic       beep;

  always #5 clk = ~clk;

  microwave_pwr #(
    .TICK_DIV   (TICK_DIV),
    .PWR_WINDOW (PWR_WINDOW),
    .DONE_BEEP_S(DONE_BEEP_S)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .keypad     (keypad),
    .key_pwr    (key_pwr),
    .start      (start),
    .stop       (stop),
    .door_closed(door_closed),
    .mag        (mag),
    .state      (state),
    .mins       (mins),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .power      (power),
    .beep       (beep)
  );

  int checks = 0;
  int errors = 0;
  bit compare_en = 1'b0;

  // Reference model. Time is kept as the decimal number MSS shown on the
  // display (1:25 -> 125); phase counts cycles since the last second.
  int m_state = S_IDLE;
  int m_time  = 0;
  int m_power = 10;
  int m_phase = 0;
  int m_win   = 0;
  int m_beeps = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int dec_time(input int t);
    if (t % 100 == 0) return t - 100 + 59;
    return t - 1;
  endfunction

  function automatic int shown_time();
    return int'(mins) * 100 + int'(sec_tens) * 10 + int'(sec_ones);
  endfunction

  // Model step on each rising edge using the inputs presented that cycle.
  always @(posedge clk) begin : model_step
    int d;
    bit dv;
    dv = ($countones(keypad) == 1);
    d = 0;
    for (int i = 0; i < 10; i++) if (keypad[i]) d = i;
    if (reset) begin
      m_state = S_IDLE; m_time = 0; m_power = 10;
      m_phase = 0; m_win = 0; m_beeps = 0;
    end else begin
      case (m_state)
        S_IDLE: begin
          if (stop) begin
            m_time = 0; m_power = 10;
          end else if (start && door_closed) begin
            if (m_time == 0) m_time = 30;
            m_state = S_COOK; m_phase = 0; m_win = 0;
          end else if (key_pwr) m_state = S_PWR;
          else if (dv) m_time = (m_time * 10 + d) % 1000;
        end
        S_PWR: begin
          if (stop) m_state = S_IDLE;
          else if (dv) begin
            m_power = (d == 0) ? 10 : d;
            m_state = S_IDLE;
          end
        end
        S_COOK: begin
          if (stop || !door_closed) m_state = S_PAUSE;
          else begin
            m_phase++;
            if (m_phase == TICK_DIV) begin
              m_phase = 0;
              m_time = dec_time(m_time);
              m_win = (m_win + 1) % PWR_WINDOW;
              if (m_time == 0) begin
                m_state = S_DONE; m_beeps = 0;
              end
            end
          end
        end
        S_PAUSE: begin
          if (stop) begin
            m_state = S_IDLE; m_time = 0; m_power = 10;
          end else if (start && door_closed) m_state = S_COOK;
        end
        default: begin
          if (stop || !door_closed || dv) m_state = S_IDLE;
          else begin
            m_phase++;
            if (m_phase == TICK_DIV) begin
              m_phase = 0;
              m_beeps++;
              if (m_beeps == DONE_BEEP_S) m_state = S_IDLE;
            end
          end
        end
      endcase
    end
  end

  // Scoreboard: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    if (compare_en) begin
      check("state", int'(state), m_state);
      check("time",  shown_time(), m_time);
      check("power", int'(power), m_power);
      check("mag",   int'(mag),
            int'(m_state == S_COOK && m_win * 10 < m_power * PWR_WINDOW));
      check("beep",  int'(beep), int'(m_state == S_DONE));
    end
  end

  // Driver tasks: called at a falling edge, apply a one-cycle pulse and
  // return at the falling edge right after the sampling rising edge.
  task automatic tap_raw(input logic [9:0] k);
    keypad = k;
    @(negedge clk);
    keypad = '0;
  endtask

  task automatic tap_digit(input int d);
    tap_raw(10'(1 << d));
  endtask

  task automatic tap_pwr();
    key_pwr = 1'b1;
    @(negedge clk);
    key_pwr = 1'b0;
  endtask

  task automatic tap_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic tap_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int cnt;

  initial begin
    // Reset
    reset = 1'b1;
    wait_cyc(2);
    compare_en = 1'b1;
    reset = 1'b0;
    check("rst_state", int'(state), 0);
    check("rst_time", shown_time(), 0);
    check("rst_power", int'(power), 10);
    check("rst_mag", int'(mag), 0);
    check("rst_beep", int'(beep), 0);

    // 1:25 countdown at full power
    tap_digit(1); tap_digit(2); tap_digit(5);
    check("entry_125", shown_time(), 125);
    tap_start();
    check("cook_state", int'(state), S_COOK);
    check("cook_mag_first", int'(mag), 1);
    check("cook_time0", shown_time(), 125);
    wait_cyc(16);
    check("after_4_ticks", shown_time(), 121);
    wait_cyc(84);
    check("at_1_00", shown_time(), 100);
    wait_cyc(4);
    check("borrow_0_59", shown_time(), 59);
    tap_stop();
    check("stop_pause", int'(state), S_PAUSE);
    tap_stop();
    check("stop_idle_time", shown_time(), 0);

    // Power 3, 0:20 run to DONE and back to IDLE
    tap_pwr();
    check("pwr_sel", int'(state), S_PWR);
    tap_digit(3);
    check("power_3", int'(power), 3);
    tap_digit(2); tap_digit(0);
    check("entry_20", shown_time(), 20);
    tap_start();
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (mag) cnt++;
      @(negedge clk);
    end
    check("mag_duty_3of10", cnt, 12);
    check("half_time", shown_time(), 10);
    wait_cyc(40);
    check("done_state", int'(state), S_DONE);
    check("done_beep", int'(beep), 1);
    check("done_mag", int'(mag), 0);
    check("done_time", shown_time(), 0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (beep) cnt++;
      @(negedge clk);
    end
    check("beep_cycles", cnt, 12);
    check("done_to_idle", int'(state), S_IDLE);
    check("beep_off", int'(beep), 0);

    // Door open mid-cook at 0:10, resume with held tick phase
    tap_stop();
    check("idle_stop_power", int'(power), 10);
    tap_digit(1); tap_digit(5);
    tap_start();
    wait_cyc(20);
    check("door_at_10", shown_time(), 10);
    wait_cyc(2);
    door_closed = 1'b0;
    @(negedge clk);
    check("door_pause", int'(state), S_PAUSE);
    check("door_mag_off", int'(mag), 0);
    wait_cyc(6);
    check("pause_held", shown_time(), 10);
    tap_start();
    check("start_door_open_ignored", int'(state), S_PAUSE);
    door_closed = 1'b1;
    tap_start();
    check("resume_state", int'(state), S_COOK);
    check("resume_mag", int'(mag), 1);
    wait_cyc(1);
    check("resume_phase_a", shown_time(), 10);
    wait_cyc(1);
    check("resume_phase_b", shown_time(), 9);
    tap_stop(); tap_stop();

    // Start and stop together in IDLE, then quick start
    tap_digit(5);
    check("entry_05", shown_time(), 5);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("startstop_state", int'(state), S_IDLE);
    check("startstop_time", shown_time(), 0);
    tap_start();
    check("quick_state", int'(state), S_COOK);
    check("quick_time", shown_time(), 30);
    tap_stop(); tap_stop();

    // Keypad corner cases
    tap_raw(10'b0000000110);
    check("multi_key_ignored", shown_time(), 0);
    tap_pwr(); tap_digit(4);
    check("power_4", int'(power), 4);
    tap_pwr(); tap_digit(0);
    check("power_0_is_10", int'(power), 10);
    tap_digit(1); tap_digit(2); tap_digit(3); tap_digit(4);
    check("shift_drop_mins", shown_time(), 234);
    door_closed = 1'b0;
    tap_start();
    check("idle_door_open_start", int'(state), S_IDLE);
    door_closed = 1'b1;
    tap_start();
    tap_digit(9);
    check("cook_key_ignored", shown_time(), 234);
    tap_pwr();
    check("cook_pwr_ignored", int'(state), S_COOK);
    tap_stop(); tap_stop();

    // DONE left immediately by a digit
    tap_digit(1);
    tap_start();
    wait_cyc(4);
    check("done_short", int'(state), S_DONE);
    tap_digit(5);
    check("done_digit_exit", int'(state), S_IDLE);
    check("done_digit_time", shown_time(), 0);

    // Reset mid-cook at 0:42 power 7
    tap_pwr(); tap_digit(7);
    tap_digit(4); tap_digit(3);
    tap_start();
    wait_cyc(4);
    check("pre_reset_time", shown_time(), 42);
    check("pre_reset_power", int'(power), 7);
    check("pre_reset_mag", int'(mag), 1);
    reset = 1'b1;
    @(negedge clk);
    check("reset_state", int'(state), S_IDLE);
    check("reset_time", shown_time(), 0);
    check("reset_power", int'(power), 10);
    check("reset_mag", int'(mag), 0);
    check("reset_beep", int'(beep), 0);
    reset = 1'b0;
    wait_cyc(3);

    compare_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
